// File: rtl/fifo32_block_packer_pkg.sv
// Shared widths and FSM encoding for the FIFO-to-AES block packer.
package fifo32_block_packer_pkg;

    localparam int unsigned AES_BLK_W     = 128;
    localparam int unsigned FIFO_WORD_W   = 32;
    localparam int unsigned WORDS_PER_BLK = 4;

    // FILL: collecting words, HOLD: complete block offered to the AES core
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/fifo32_block_packer.sv
// Pops 32-bit words from the controller FIFO and packs four of them into one
// 128-bit AES block, offered to the AES core over valid/ready.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   fifo_empty    FIFO has no readable word
//   fifo_rd_en    pop request (combinational); data returns next cycle
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   flush         synchronous abort of the partial or held block
//   blk_valid     blk_data holds a complete block
//   blk_ready     AES core accepts the block
//   blk_data      assembled block, word 0 in the most significant slot
//   word_cnt      words captured in the current block (0..4)
//   blk_cnt       blocks delivered since reset, wraps
module fifo32_block_packer
    import fifo32_block_packer_pkg::*;
#(
    parameter int unsigned WORD_W = FIFO_WORD_W,
    parameter int unsigned WORDS  = WORDS_PER_BLK,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [WORD_W-1:0]         fifo_rd_data,
    input  logic                      flush,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic [WORD_W*WORDS-1:0]   blk_data,
    output logic [2:0]                word_cnt,
    output logic [CNT_W-1:0]          blk_cnt
);

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       pend_q;
    logic       capture;
    logic       last_word;
    logic       handshake;

    // A read is in flight whenever pend_q is set; flush drops its data.
    assign capture   = pend_q & ~flush;
    assign last_word = capture & (word_cnt == 3'(WORDS - 1));
    assign handshake = (state_q == ST_HOLD) & blk_ready & ~flush;

    // Issued plus outstanding words never exceed one block.
    assign fifo_rd_en = (state_q == ST_FILL) & ~fifo_empty & ~flush &
                        ((4'(word_cnt) + 4'(pend_q)) < 4'(WORDS));

    // Next-state logic; flush wins over the handshake
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: if (last_word) state_d = ST_HOLD;
                ST_HOLD: if (blk_ready) state_d = ST_FILL;
                default: state_d = ST_FILL;
            endcase
        end
    end

    // State, handshake and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            blk_valid <= 1'b0;
            pend_q    <= 1'b0;
            word_cnt  <= 3'd0;
            blk_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            blk_valid <= (state_d == ST_HOLD);
            pend_q    <= fifo_rd_en;
            if (flush || handshake) begin
                word_cnt <= 3'd0;
            end else if (capture) begin
                word_cnt <= word_cnt + 3'd1;
            end
            if (handshake) begin
                blk_cnt <= blk_cnt + CNT_W'(1);
            end
        end
    end

    // Slot register: word n lands at bits [(WORDS-1-n)*WORD_W +: WORD_W]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_data <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (word_cnt == 3'(i)) begin
                    blk_data[(WORDS-1-i)*WORD_W +: WORD_W] <= fifo_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo32_block_packer.sv
// Directed self-checking bench for fifo32_block_packer with a behavioural
// FIFO read port (one-cycle read latency) and a narrow-counter twin instance.
module tb_fifo32_block_packer;
    import fifo32_block_packer_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic [FIFO_WORD_W-1:0]  fifo_rd_data;
    logic                    flush;
    logic                    blk_valid;
    logic                    blk_ready;
    logic [AES_BLK_W-1:0]    blk_data;
    logic [2:0]              word_cnt;
    logic [15:0]             blk_cnt;

    logic                    fifo_rd_en_w;
    logic                    blk_valid_w;
    logic [AES_BLK_W-1:0]    blk_data_w;
    logic [2:0]              word_cnt_w;
    logic [2:0]              blk_cnt_w;

    logic [FIFO_WORD_W-1:0]  mem [0:1023];
    int                      wr_ptr = 0;
    int                      rd_ptr = 0;
    int                      underflow_cnt = 0;
    int                      n_checks = 0;
    int                      n_fail = 0;
    int                      n;

    always #5 clk = ~clk;

    fifo32_block_packer u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .flush(flush), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .word_cnt(word_cnt), .blk_cnt(blk_cnt)
    );

    fifo32_block_packer #(.CNT_W(3)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_w),
        .fifo_rd_data(fifo_rd_data), .flush(flush), .blk_valid(blk_valid_w),
        .blk_ready(blk_ready), .blk_data(blk_data_w), .word_cnt(word_cnt_w), .blk_cnt(blk_cnt_w)
    );

    // Behavioural FIFO read port
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst_n && fifo_rd_en && fifo_empty) underflow_cnt <= underflow_cnt + 1;
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 1024];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [FIFO_WORD_W-1:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc);
        int k;
        k = 0;
        while (!blk_valid && k < max_cyc) begin
            @(negedge clk); #1;
            k++;
        end
        check_val("wait_valid", 128'(blk_valid), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0; flush = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_rd_en",    128'(fifo_rd_en), 128'(0));
        check_val("rst_valid",    128'(blk_valid),  128'(0));
        check_val("rst_word_cnt", 128'(word_cnt),   128'(0));
        check_val("rst_blk_cnt",  128'(blk_cnt),    128'(0));
        check_val("rst_blk_data", blk_data,         128'(0));
        @(negedge clk); rst_n = 1'b1;

        // Basic block with ready high: 4 reads, valid 5 cycles after first read
        @(negedge clk);
        blk_ready = 1'b1;
        push(32'h0011_2233); push(32'h4455_6677); push(32'h8899_AABB); push(32'hCCDD_EEFF);
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            check_val($sformatf("t1_rd_en_c%0d", c),  128'(fifo_rd_en), 128'(c < 4));
            check_val($sformatf("t1_valid_c%0d", c),  128'(blk_valid),  128'(c == 5));
        end
        check_val("t1_data", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        @(negedge clk); #1;
        check_val("t1_valid_after", 128'(blk_valid), 128'(0));
        check_val("t1_blk_cnt",     128'(blk_cnt),   128'(1));
        check_val("t1_word_cnt",    128'(word_cnt),  128'(0));

        // Same block, core stalls 10 cycles; FIFO refilled during HOLD
        blk_ready = 1'b0;
        push(32'h0011_2233); push(32'h4455_6677); push(32'h8899_AABB); push(32'hCCDD_EEFF);
        wait_valid(8);
        push(32'h0123_4567); push(32'h89AB_CDEF);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            check_val("t2_hold_valid", 128'(blk_valid),  128'(1));
            check_val("t2_hold_data",  blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
            check_val("t2_hold_rd_en", 128'(fifo_rd_en), 128'(0));
        end
        @(negedge clk); blk_ready = 1'b1; #1;
        check_val("t2_valid_at_ready", 128'(blk_valid), 128'(1));
        @(negedge clk); #1;
        check_val("t2_valid_after", 128'(blk_valid), 128'(0));
        check_val("t2_blk_cnt",     128'(blk_cnt),   128'(2));

        // Two words, FIFO empty for 7 cycles, two more words
        repeat (3) begin @(negedge clk); #1; end
        for (int c = 0; c < 7; c++) begin
            check_val("t3_park_cnt",  128'(word_cnt),   128'(2));
            check_val("t3_park_rd_en", 128'(fifo_rd_en), 128'(0));
            @(negedge clk); #1;
        end
        push(32'hFEDC_BA98); push(32'h7654_3210);
        wait_valid(8);
        check_val("t3_data",    blk_data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        check_val("t3_blk_cnt", 128'(blk_cnt), 128'(2));

        // Flush with the third read outstanding
        @(negedge clk);
        push(32'hA0A0_A0A0); push(32'hA1A1_A1A1); push(32'hA2A2_A2A2); push(32'hA3A3_A3A3);
        #1;
        check_val("t4_blk_cnt_pre", 128'(blk_cnt),   128'(3));
        check_val("t4_rd_en_c0",    128'(fifo_rd_en), 128'(1));
        @(negedge clk); #1;
        check_val("t4_rd_en_c1",    128'(fifo_rd_en), 128'(1));
        @(negedge clk); #1;
        check_val("t4_rd_en_c2",    128'(fifo_rd_en), 128'(1));
        @(negedge clk); flush = 1'b1; #1;
        check_val("t4_rd_en_flush", 128'(fifo_rd_en), 128'(0));
        @(negedge clk); flush = 1'b0;
        push(32'hB0B0_B0B0); push(32'hB1B1_B1B1); push(32'hB2B2_B2B2);
        #1;
        check_val("t4_word_cnt", 128'(word_cnt), 128'(0));
        check_val("t4_blk_cnt",  128'(blk_cnt),  128'(3));
        wait_valid(8);
        check_val("t4_data", blk_data, 128'hA3A3A3A3_B0B0B0B0_B1B1B1B1_B2B2B2B2);

        // flush together with ready in HOLD
        @(negedge clk);
        blk_ready = 1'b0;
        push(32'hC0C0_C0C0); push(32'hC1C1_C1C1); push(32'hC2C2_C2C2); push(32'hC3C3_C3C3);
        #1;
        check_val("t5_blk_cnt_pre", 128'(blk_cnt), 128'(4));
        wait_valid(8);
        check_val("t5_data", blk_data, 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3);
        @(negedge clk); flush = 1'b1; blk_ready = 1'b1; #1;
        @(negedge clk); flush = 1'b0; #1;
        check_val("t5_valid",    128'(blk_valid), 128'(0));
        check_val("t5_blk_cnt",  128'(blk_cnt),   128'(4));
        check_val("t5_word_cnt", 128'(word_cnt),  128'(0));

        // Stream five blocks: one per 6 cycles, narrow counter wraps to 1
        @(negedge clk);
        for (int i = 0; i < 20; i++) push(32'h1000_0000 + 32'(i));
        #1;
        n = 0;
        while (blk_cnt != 16'd9 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("t6_cycles",      128'(n),          128'(30));
        check_val("t6_blk_cnt",     128'(blk_cnt),    128'(9));
        check_val("t6_blk_cnt_w",   128'(blk_cnt_w),  128'(1));
        check_val("t6_data",        blk_data,   128'h10000010_10000011_10000012_10000013);
        check_val("t6_data_w",      blk_data_w, 128'h10000010_10000011_10000012_10000013);
        check_val("t6_valid_w",     128'(blk_valid_w), 128'(0));
        check_val("t6_word_cnt_w",  128'(word_cnt_w),  128'(0));
        check_val("t6_rd_en_w",     128'(fifo_rd_en_w), 128'(0));

        // Reset mid-block drops the partial block
        @(negedge clk);
        push(32'hD0D0_D0D0); push(32'hD1D1_D1D1);
        #1;
        repeat (3) begin @(negedge clk); #1; end
        check_val("t7_word_cnt_pre", 128'(word_cnt), 128'(2));
        rst_n = 1'b0;
        #1;
        check_val("t7_word_cnt",  128'(word_cnt),  128'(0));
        check_val("t7_blk_cnt",   128'(blk_cnt),   128'(0));
        check_val("t7_blk_cnt_w", 128'(blk_cnt_w), 128'(0));
        check_val("t7_blk_data",  blk_data,        128'(0));
        check_val("t7_rd_en",     128'(fifo_rd_en), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;

        check_val("no_underflow", 128'(underflow_cnt), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo32_block_packer.md
Name: fifo32_block_packer

Overview:
- Read-side consumer of the 32-bit controller FIFO in the AES-128 verify platform.
- Pops 32-bit words from the FIFO read port and assembles four of them into one 128-bit AES block.
- Presents each block to the AES core through a valid/ready handshake.
- Counterpart to the write side that fills the FIFO from the host interface.

Parameters:
- WORD_W, 32: FIFO word width in bits.
- WORDS, 4: words per block. Block width is WORD_W*WORDS = 128.
- CNT_W, 16: width of the delivered-block counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO has no readable word.
- fifo_rd_en  output  1  pop request. Data returns one cycle later.
- fifo_rd_data  input  WORD_W  FIFO read data. Valid the cycle after fifo_rd_en.
- flush  input  1  synchronous abort of the partial or held block.
- blk_valid  output  1  blk_data holds a complete block.
- blk_ready  input  1  AES core accepts the block.
- blk_data  output  WORD_W*WORDS  assembled block.
- word_cnt  output  3  words captured in the current block (0..4).
- blk_cnt  output  CNT_W  blocks delivered since reset. Wraps.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous active-low on rst_n.
- Reset values: every output and register is 0, including fifo_rd_en, blk_valid, blk_data, word_cnt, blk_cnt and the internal pend flag.
- States:
  - FILL: word_cnt < 4, blk_valid = 0.
  - HOLD: word_cnt = 4, blk_valid = 1.
- Read issue (combinational): fifo_rd_en = FILL & ~fifo_empty & ~flush & (word_cnt + pend < WORDS).
  - pend is a register: pend <= fifo_rd_en.
  - At most one read is outstanding. Back-to-back reads are allowed.
  - fifo_rd_en is never asserted while fifo_empty = 1 (no underflow).
- Capture: when pend = 1, fifo_rd_data is written into slot word_cnt and word_cnt increments.
  - Word 0 goes to blk_data[127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0] (FIPS-197 byte order).
  - The cycle word_cnt reaches 4, the next state is HOLD and blk_valid rises on the following edge (registered).
- Handshake:
  - In HOLD, blk_data and blk_valid are stable until blk_valid & blk_ready is sampled at a clock edge.
  - On the handshake: word_cnt <= 0, blk_valid <= 0, blk_cnt <= blk_cnt + 1 (mod 2^CNT_W), return to FILL.
  - No reads are issued in HOLD.
  - blk_ready while blk_valid = 0 is ignored.
- Throughput with a never-empty FIFO: first block valid 5 cycles after the first rd_en. Steady state is one block per 6 cycles.
- Stalls: if the FIFO empties mid-block, word_cnt holds and reads resume when fifo_empty deasserts. There is no timeout.
- flush:
  - Next state is FILL with word_cnt = 0, blk_valid = 0.
  - Read data from a read issued before flush (pend = 1) is discarded and pend clears.
  - blk_data contents are don't-care.
  - blk_cnt does not increment, even if blk_ready = 1 in the same cycle. flush has priority over the handshake.
- blk_data retains its last value after the handshake until overwritten.
- Reset mid-block drops the partial block immediately. In-flight FIFO data is lost; the FIFO owner is responsible for re-sync.

Decomposition:
- Shared package: AES_BLK_W = 128, FIFO_WORD_W = 32, WORDS_PER_BLK = 4, and the FILL/HOLD state encoding (1 bit).
- No sub-module is needed. The read-issue and capture logic and the 128-bit shift/slot register live in one module.

Test Plan:
- Reset then push words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with blk_ready = 1 -> rd_en asserts for 4 consecutive cycles. blk_valid rises 5 cycles after the first rd_en with blk_data = 0x00112233_44556677_8899AABB_CCDDEEFF. blk_cnt = 1 after the handshake.
- Same block with blk_ready = 0 for 10 cycles -> blk_valid stays 1, blk_data unchanged, rd_en = 0 throughout HOLD. Accepted on the cycle ready = 1.
- Push 2 words, hold FIFO empty 7 cycles, push 2 more -> word_cnt parks at 2 with no rd_en during empty. Block completes with correct order.
- Assert flush on the cycle after the 3rd rd_en (pend = 1) -> 3rd word discarded, word_cnt = 0, blk_cnt unchanged. The next 4 words form a fresh correct block.
- flush and blk_ready together in HOLD -> blk_valid = 0, blk_cnt not incremented.
- Stream 65537 blocks with a CNT_W = 16 counter -> blk_cnt wraps to 1. No rd_en is ever asserted with fifo_empty = 1 (assertion).
